aci_tape_player: RTL and testbench

- Digital cassette playback source that sits directly upstream of the ACI and drives its tape_in pin.
- Consumes a byte stream, e.g. from the ioctl/SD download buffer.
- Emits the Apple-1 ACI waveform: leader tone, sync cycle, then MSB-first data bits. A 1 bit is one long cycle; a 0 bit is one short cycle.
- Replaces the analog audio input when loading tape images.

---
 rtl/aci_pkg.sv | 22 ++
 rtl/aci_half_timer.sv | 24 ++
 rtl/aci_tape_player.sv | 131 +++++++++++++
 tb/tb_aci_tape_player.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aci_pkg.sv
// aci_pkg: shared states, default half-periods and timer sizing for the ACI tape player
package aci_pkg;

    typedef enum logic [2:0] {IDLE, LEADER, SYNC, LOAD, BITS} state_t;

    localparam int unsigned DEF_HALF_LEADER   = 8949;
    localparam int unsigned DEF_HALF_SYNC     = 2864;
    localparam int unsigned DEF_HALF_ONE      = 7159;
    localparam int unsigned DEF_HALF_ZERO     = 3580;
    localparam int unsigned DEF_LEADER_CYCLES = 2048;

    // Narrowest counter that can hold the longest half-period minus one
    function automatic int unsigned timer_width(input int unsigned a, input int unsigned b,
                                                input int unsigned c, input int unsigned d);
        int unsigned m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        m = (m > d) ? m : d;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/aci_half_timer.sv
// aci_half_timer: down-counter that measures one half-period of the tape waveform
module aci_half_timer #(
    parameter int unsigned W = 14
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         load_i,
    input  logic [W-1:0] period_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q;

    // period_i carries the half-period minus one, so a load followed by the
    // countdown to zero spans exactly one half-period
    always_ff @(posedge clk_i) begin
        if (reset_i) cnt_q <= '0;
        else if (load_i) cnt_q <= period_i;
        else if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end

    assign expire_o = cnt_q == '0;

endmodule

// File: rtl/aci_tape_player.sv
// aci_tape_player: plays a byte stream as an Apple-1 ACI cassette waveform
module aci_tape_player
    import aci_pkg::*;
#(
    parameter int unsigned HALF_LEADER   = DEF_HALF_LEADER,
    parameter int unsigned HALF_SYNC     = DEF_HALF_SYNC,
    parameter int unsigned HALF_ONE      = DEF_HALF_ONE,
    parameter int unsigned HALF_ZERO     = DEF_HALF_ZERO,
    parameter int unsigned LEADER_CYCLES = DEF_LEADER_CYCLES
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [7:0]  in_data_i,
    input  logic        in_valid_i,
    input  logic        in_last_i,
    output logic        in_ready_o,
    output logic        tape_bit_o,
    output logic        busy_o,
    output logic        underrun_o,
    output logic [15:0] byte_count_o
);

    localparam int unsigned TW = timer_width(HALF_LEADER, HALF_SYNC, HALF_ONE, HALF_ZERO);
    localparam logic [TW-1:0] P_LEADER = TW'(HALF_LEADER - 1);
    localparam logic [TW-1:0] P_SYNC   = TW'(HALF_SYNC - 1);
    localparam logic [TW-1:0] P_ONE    = TW'(HALF_ONE - 1);
    localparam logic [TW-1:0] P_ZERO   = TW'(HALF_ZERO - 1);

    state_t        state_q;
    logic          tape_q;
    logic          last_q;
    logic          underrun_q;
    logic [15:0]   lead_q;
    logic [15:0]   count_q;
    logic [7:0]    data_q;
    logic [2:0]    idx_q;
    logic          expire;
    logic          tmr_load;
    logic          last_lead;
    logic [TW-1:0] tmr_period;

    assign last_lead = lead_q == 16'(LEADER_CYCLES - 1);

    // Reload the timer on every edge the FSM takes; in BITS the high half uses
    // the current bit and the low half already looks ahead to the next one
    always_comb begin
        tmr_load   = (state_q == IDLE) ? start_i :
                     (state_q == LOAD) ? in_valid_i : expire;
        tmr_period = (state_q == LOAD) ? (in_data_i[7] ? P_ONE : P_ZERO) :
                     (state_q == BITS) ? ((tape_q ? data_q[7] : data_q[6]) ? P_ONE : P_ZERO) :
                     (state_q == SYNC || (state_q == LEADER && !tape_q && last_lead)) ? P_SYNC :
                     P_LEADER;
    end

    aci_half_timer #(.W(TW)) u_timer (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .load_i   (tmr_load),
        .period_i (tmr_period),
        .expire_o (expire)
    );

    // Playback sequencer: leader, sync, then one byte at a time MSB first
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            tape_q     <= 1'b0;
            last_q     <= 1'b0;
            underrun_q <= 1'b0;
            lead_q     <= '0;
            count_q    <= '0;
            data_q     <= '0;
            idx_q      <= '0;
        end else if (abort_i) begin
            state_q <= IDLE;
            tape_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start_i) begin
                    state_q    <= LEADER;
                    tape_q     <= 1'b1;
                    lead_q     <= '0;
                    underrun_q <= 1'b0;
                    count_q    <= '0;
                end
                LEADER: if (expire) begin
                    if (tape_q) tape_q <= 1'b0;
                    else begin
                        tape_q <= 1'b1;
                        if (last_lead) state_q <= SYNC;
                        else lead_q <= lead_q + 16'd1;
                    end
                end
                SYNC: if (expire) begin
                    if (tape_q) tape_q <= 1'b0;
                    else state_q <= LOAD;
                end
                LOAD: if (in_valid_i) begin
                    data_q  <= in_data_i;
                    last_q  <= in_last_i;
                    count_q <= count_q + 16'd1;
                    idx_q   <= 3'd7;
                    tape_q  <= 1'b1;
                    state_q <= BITS;
                end else underrun_q <= 1'b1;
                BITS: if (expire) begin
                    if (tape_q) tape_q <= 1'b0;
                    else if (idx_q == 3'd0) state_q <= last_q ? IDLE : LOAD;
                    else begin
                        idx_q  <= idx_q - 3'd1;
                        data_q <= data_q << 1;
                        tape_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tape_q  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o   = state_q == LOAD;
    assign busy_o       = state_q != IDLE;
    assign tape_bit_o   = tape_q;
    assign underrun_o   = underrun_q;
    assign byte_count_o = count_q;

endmodule

// File: tb/tb_aci_tape_player.sv
// tb_aci_tape_player: directed waveform checks for the ACI tape player
module tb_aci_tape_player;

    logic        clk = 1'b0;
    logic        reset, start, abort;
    logic [7:0]  in_data;
    logic        in_valid, in_last, in_ready;
    logic        tape_bit, busy, underrun;
    logic [15:0] byte_count;

    int n_checks = 0;
    int n_fail   = 0;
    int xfers    = 0;
    int ready_cnt = 0;
    int gap_cnt  = 0;
    int gap_at   = -1;
    int src_pos  = 0;
    int x0, r0;
    logic [7:0] src_d[$];
    logic       src_l[$];

    always #5 clk = ~clk;

    aci_tape_player #(
        .HALF_LEADER(8), .HALF_SYNC(3), .HALF_ONE(6), .HALF_ZERO(4), .LEADER_CYCLES(2)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .start_i      (start),
        .abort_i      (abort),
        .in_data_i    (in_data),
        .in_valid_i   (in_valid),
        .in_last_i    (in_last),
        .in_ready_o   (in_ready),
        .tape_bit_o   (tape_bit),
        .busy_o       (busy),
        .underrun_o   (underrun),
        .byte_count_o (byte_count)
    );

    // Byte source: offers queued bytes, optionally withholding one for 20 ready clks
    initial begin
        logic fire;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        forever begin
            @(negedge clk);
            fire = in_valid && in_ready;
            if (in_ready) ready_cnt++;
            if (in_ready && !in_valid && src_pos == gap_at) gap_cnt++;
            @(posedge clk);
            #1;
            if (fire) begin
                xfers++;
                src_pos++;
            end
            in_valid = src_pos < src_d.size() && !(src_pos == gap_at && gap_cnt < 20);
            in_data  = (src_pos < src_d.size()) ? src_d[src_pos] : 8'h00;
            in_last  = (src_pos < src_d.size()) ? src_l[src_pos] : 1'b0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Measures one run of constant tape_bit/busy starting at the current negedge
    task automatic expect_run(input string tag, input logic lvl, input int len);
        logic l, b;
        int n;
        l = tape_bit;
        b = busy;
        n = 1;
        while (n < 200) begin
            @(negedge clk);
            if (tape_bit !== l || busy !== b) break;
            n++;
        end
        check({tag, " level"}, {31'd0, l}, {31'd0, lvl});
        check({tag, " length"}, n, len);
    endtask

    task automatic expect_leader(input string tag);
        for (int c = 0; c < 2; c++) begin
            expect_run($sformatf("%s lead%0d hi", tag, c), 1'b1, 8);
            expect_run($sformatf("%s lead%0d lo", tag, c), 1'b0, 8);
        end
        expect_run({tag, " sync hi"}, 1'b1, 3);
        expect_run({tag, " sync lo"}, 1'b0, 4);
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] b, input int tail);
        for (int i = 7; i >= 0; i--) begin
            int h;
            h = b[i] ? 6 : 4;
            expect_run($sformatf("%s b%0d hi", tag, i), 1'b1, h);
            expect_run($sformatf("%s b%0d lo", tag, i), 1'b0, (i == 0) ? h + tail : h);
        end
    endtask

    task automatic add_byte(input logic [7:0] d, input logic l);
        src_d.push_back(d);
        src_l.push_back(l);
    endtask

    task automatic start_play();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        repeat (3) @(negedge clk);
        check("rst tape", {31'd0, tape_bit}, 0);
        check("rst busy", {31'd0, busy}, 0);
        check("rst ready", {31'd0, in_ready}, 0);
        check("rst underrun", {31'd0, underrun}, 0);
        check("rst count", {16'd0, byte_count}, 0);
        reset = 1'b0;

        x0 = xfers;
        r0 = ready_cnt;
        add_byte(8'hA5, 1'b1);
        @(negedge clk);
        start_play();
        expect_leader("one");
        expect_byte("one A5", 8'hA5, 0);
        check("one busy", {31'd0, busy}, 0);
        check("one tape", {31'd0, tape_bit}, 0);
        check("one count", {16'd0, byte_count}, 1);
        check("one xfers", xfers - x0, 1);
        check("one ready clks", ready_cnt - r0, 1);

        x0 = xfers;
        r0 = ready_cnt;
        add_byte(8'h00, 1'b0);
        add_byte(8'hFF, 1'b0);
        add_byte(8'h3C, 1'b1);
        @(negedge clk);
        start_play();
        expect_leader("multi");
        expect_byte("multi 00", 8'h00, 1);
        expect_byte("multi FF", 8'hFF, 1);
        expect_byte("multi 3C", 8'h3C, 0);
        check("multi busy", {31'd0, busy}, 0);
        check("multi count", {16'd0, byte_count}, 3);
        check("multi xfers", xfers - x0, 3);
        check("multi ready clks", ready_cnt - r0, 3);

        gap_at = src_d.size() + 1;
        add_byte(8'h81, 1'b0);
        add_byte(8'h42, 1'b1);
        @(negedge clk);
        start_play();
        expect_leader("ur");
        check("ur underrun before", {31'd0, underrun}, 0);
        expect_byte("ur 81", 8'h81, 21);
        check("ur underrun set", {31'd0, underrun}, 1);
        check("ur gap clks", gap_cnt, 20);
        expect_byte("ur 42", 8'h42, 0);
        check("ur underrun sticky", {31'd0, underrun}, 1);
        check("ur count", {16'd0, byte_count}, 2);
        check("ur busy", {31'd0, busy}, 0);

        add_byte(8'h96, 1'b1);
        @(negedge clk);
        start_play();
        check("ab underrun cleared", {31'd0, underrun}, 0);
        check("ab count cleared", {16'd0, byte_count}, 0);
        expect_leader("ab");
        expect_run("ab b7 hi", 1'b1, 6);
        expect_run("ab b7 lo", 1'b0, 6);
        expect_run("ab b6 hi", 1'b1, 4);
        expect_run("ab b6 lo", 1'b0, 4);
        expect_run("ab b5 hi", 1'b1, 4);
        expect_run("ab b5 lo", 1'b0, 4);
        check("ab b4 high", {31'd0, tape_bit}, 1);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("ab tape", {31'd0, tape_bit}, 0);
        check("ab busy", {31'd0, busy}, 0);
        check("ab ready", {31'd0, in_ready}, 0);
        check("ab count held", {16'd0, byte_count}, 1);

        add_byte(8'h96, 1'b1);
        @(negedge clk);
        start_play();
        expect_leader("re");
        start = 1'b1;
        expect_byte("re 96", 8'h96, 0);
        start = 1'b0;
        check("re busy", {31'd0, busy}, 0);
        check("re count", {16'd0, byte_count}, 1);

        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("sa busy", {31'd0, busy}, 0);
        check("sa tape", {31'd0, tape_bit}, 0);
        @(negedge clk);
        check("sa busy later", {31'd0, busy}, 0);

        add_byte(8'h55, 1'b1);
        @(negedge clk);
        start_play();
        for (int c = 0; c < 2; c++) begin
            expect_run($sformatf("rs lead%0d hi", c), 1'b1, 8);
            expect_run($sformatf("rs lead%0d lo", c), 1'b0, 8);
        end
        check("rs sync high", {31'd0, tape_bit}, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rs tape", {31'd0, tape_bit}, 0);
        check("rs busy", {31'd0, busy}, 0);
        check("rs ready", {31'd0, in_ready}, 0);
        check("rs underrun", {31'd0, underrun}, 0);
        check("rs count", {16'd0, byte_count}, 0);
        repeat (2) @(negedge clk);
        check("rs stays idle", {31'd0, busy}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
